// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder with valid/ready handshakes on both sides.
// Each frame of FRAME_LEN information bits is followed by three zero tail bits.
module conv_encoder #(
    parameter int unsigned FRAME_LEN = 1021,
    parameter logic [3:0]  G0        = 4'b1111,
    parameter logic [3:0]  G1        = 4'b1101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] d_out,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int unsigned CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t          state_q, state_d;
    logic [2:0]      s_q, s_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [1:0]      tail_cnt_q, tail_cnt_d;
    logic [1:0]      dout_q, dout_d;
    logic            last_q, last_d;
    logic            valid_q, valid_d;

    logic            slot_free, accept, tail_load, tail_done, load, u;
    logic [3:0]      v;
    logic [1:0]      sym;

    // in_ready is gated by rst so it reads 0 for the whole time reset is held
    assign slot_free = !valid_q || out_ready;
    assign in_ready  = rst && enable && slot_free && (state_q != TAIL);
    assign accept    = in_valid && in_ready;
    assign tail_load = (state_q == TAIL) && enable && slot_free;
    assign tail_done = tail_load && (tail_cnt_q == 2'd2);
    assign load      = accept || tail_load;
    assign u         = accept ? in_bit : 1'b0;
    assign v         = {u, s_q};
    assign sym       = {^(G0 & v), ^(G1 & v)};

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        dout_d     = dout_q;
        last_d     = last_q;
        valid_d    = valid_q;
        if (!enable) begin
            state_d    = IDLE;
            s_d        = '0;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            dout_d     = '0;
            last_d     = 1'b0;
            valid_d    = 1'b0;
        end else begin
            if (load) begin
                s_d     = {u, s_q[2:1]};
                dout_d  = sym;
                valid_d = 1'b1;
                last_d  = tail_done;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
            case (state_q)
                IDLE: if (accept) begin
                    bit_cnt_d = CW'(1);
                    state_d   = (FRAME_LEN == 1) ? TAIL : DATA;
                end
                DATA: if (accept) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) state_d = TAIL;
                end
                TAIL: if (tail_load) begin
                    if (tail_done) begin
                        tail_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= '0;
            dout_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            dout_q     <= dout_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
        end
    end

    assign d_out     = dout_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

    // The zero tail must always flush the trellis back to state 0.
    a_tail_flushes: assert property (@(posedge clk) disable iff (!rst)
        (enable && state_q == TAIL && state_d == IDLE) |=> (s_q == 3'b000));

endmodule
